// File: rtl/nxn_board_engine_if.sv
// Move-request channel between the input controller (master) and the board engine (slave).
interface nxn_board_engine_if #(
  parameter int N = 3
);
  localparam int CW = $clog2(N);

  logic          move_valid;
  logic          move_ready;
  logic [1:0]    move_player;
  logic [CW-1:0] move_row;
  logic [CW-1:0] move_col;
  logic          move_err;

  modport master (
    output move_valid, move_player, move_row, move_col,
    input  move_ready, move_err
  );

  modport slave (
    input  move_valid, move_player, move_row, move_col,
    output move_ready, move_err
  );
endinterface

// File: rtl/nxn_board_engine.sv
// N x N board with turn enforcement; after each accepted move it walks only the four
// lines through that move, one cell per cycle, looking for K in a row.
//
// state | meaning
// IDLE  | waiting for a move request
// SCAN  | probing cells along the lines through the last move
// OVER  | game decided (win or draw); only reset/clear leaves
module nxn_board_engine #(
  parameter int N = 3,
  parameter int K = 3
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  nxn_board_engine_if.slave           mv,
  input  logic [$clog2(N)-1:0]        rd_row,
  input  logic [$clog2(N)-1:0]        rd_col,
  output logic [1:0]                  rd_cell,
  output logic [1:0]                  win,
  output logic                        draw,
  output logic                        busy,
  output logic [$clog2(N*N+1)-1:0]    moves
);
  localparam int CW = $clog2(N);
  localparam int MW = $clog2(N*N+1);
  localparam int NC = N*N;
  localparam int PW = CW + 2;
  localparam int KW = CW + 1;
  localparam logic [KW-1:0] K_M1 = KW'(K - 1);
  localparam logic signed [PW-1:0] ZERO = 0;
  localparam logic signed [PW-1:0] ONE  = 1;
  localparam logic signed [PW-1:0] MONE = -1;

  typedef enum logic [1:0] {IDLE, SCAN, OVER} state_t;

  state_t                 state_q, state_d;
  logic [1:0]             cells_q [NC];
  logic [1:0]             cells_d [NC];
  logic [1:0]             win_q, win_d;
  logic [1:0]             turn_q, turn_d;
  logic [1:0]             player_q, player_d;
  logic [1:0]             dir_q, dir_d;
  logic                   draw_q, draw_d;
  logic                   err_q, err_d;
  logic                   neg_q, neg_d;
  logic [MW-1:0]          moves_q, moves_d;
  logic [KW-1:0]          cnt_q, cnt_d;
  logic signed [PW-1:0]   lrow_q, lrow_d, lcol_q, lcol_d;
  logic signed [PW-1:0]   pr_q, pr_d, pc_q, pc_d;

  logic [1:0]             tgt_cell, probe_cell;
  logic signed [PW-1:0]   dr, dc;
  logic                   bad_move;

  // Out-of-range coordinates read as empty, which also terminates a scan run at the edge.
  function automatic logic [1:0] cell_at(input logic [1:0] cells [NC], input int r, input int c);
    logic [1:0] v;
    v = 2'b00;
    if (r >= 0 && r < N && c >= 0 && c < N) begin
      for (int i = 0; i < NC; i++) begin
        if (i == r*N + c) v = cells[i];
      end
    end
    return v;
  endfunction

  // Direction order H, V, diag, anti; positive step is +row except H.
  function automatic logic signed [PW-1:0] step_r(input logic [1:0] d);
    return (d == 2'd0) ? ZERO : ONE;
  endfunction

  function automatic logic signed [PW-1:0] step_c(input logic [1:0] d);
    return (d == 2'd1) ? ZERO : ((d == 2'd3) ? MONE : ONE);
  endfunction

  assign tgt_cell   = cell_at(cells_q, int'(mv.move_row), int'(mv.move_col));
  assign probe_cell = cell_at(cells_q, int'(pr_q), int'(pc_q));
  assign dr         = step_r(dir_q);
  assign dc         = step_c(dir_q);
  assign bad_move   = (mv.move_player == 2'b00) || (mv.move_player == 2'b11) ||
                      (mv.move_player != turn_q) ||
                      (int'(mv.move_row) >= N) || (int'(mv.move_col) >= N) ||
                      (tgt_cell != 2'b00);

  always_comb begin
    state_d  = state_q;
    cells_d  = cells_q;
    win_d    = win_q;
    turn_d   = turn_q;
    player_d = player_q;
    dir_d    = dir_q;
    draw_d   = draw_q;
    err_d    = 1'b0;
    neg_d    = neg_q;
    moves_d  = moves_q;
    cnt_d    = cnt_q;
    lrow_d   = lrow_q;
    lcol_d   = lcol_q;
    pr_d     = pr_q;
    pc_d     = pc_q;

    if (clear) begin
      state_d = IDLE;
      for (int i = 0; i < NC; i++) cells_d[i] = 2'b00;
      win_d   = 2'b00;
      turn_d  = 2'b01;
      draw_d  = 1'b0;
      moves_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (mv.move_valid) begin
            if (bad_move) begin
              err_d = 1'b1;
            end else begin
              for (int i = 0; i < NC; i++) begin
                if (i == int'(mv.move_row)*N + int'(mv.move_col)) cells_d[i] = mv.move_player;
              end
              moves_d  = moves_q + MW'(1);
              turn_d   = turn_q ^ 2'b11;
              player_d = mv.move_player;
              lrow_d   = {2'b00, mv.move_row};
              lcol_d   = {2'b00, mv.move_col};
              pr_d     = {2'b00, mv.move_row};
              pc_d     = {2'b00, mv.move_col} + ONE;
              dir_d    = 2'd0;
              neg_d    = 1'b0;
              cnt_d    = KW'(1);
              state_d  = SCAN;
            end
          end
        end
        SCAN: begin
          if (probe_cell == player_q) begin
            cnt_d = cnt_q + KW'(1);
            if (cnt_q == K_M1) begin
              win_d   = player_q;
              state_d = OVER;
            end else if (neg_q) begin
              pr_d = pr_q - dr;
              pc_d = pc_q - dc;
            end else begin
              pr_d = pr_q + dr;
              pc_d = pc_q + dc;
            end
          end else if (!neg_q) begin
            neg_d = 1'b1;
            pr_d  = lrow_q - dr;
            pc_d  = lcol_q - dc;
          end else if (dir_q == 2'd3) begin
            if (moves_q == MW'(NC)) begin
              draw_d  = 1'b1;
              state_d = OVER;
            end else begin
              state_d = IDLE;
            end
          end else begin
            dir_d = dir_q + 2'd1;
            neg_d = 1'b0;
            cnt_d = KW'(1);
            pr_d  = lrow_q + step_r(dir_q + 2'd1);
            pc_d  = lcol_q + step_c(dir_q + 2'd1);
          end
        end
        OVER: begin
          if (mv.move_valid) err_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      for (int i = 0; i < NC; i++) cells_q[i] <= 2'b00;
      win_q    <= 2'b00;
      turn_q   <= 2'b01;
      player_q <= 2'b00;
      dir_q    <= 2'd0;
      draw_q   <= 1'b0;
      err_q    <= 1'b0;
      neg_q    <= 1'b0;
      moves_q  <= '0;
      cnt_q    <= '0;
      lrow_q   <= '0;
      lcol_q   <= '0;
      pr_q     <= '0;
      pc_q     <= '0;
    end else begin
      state_q  <= state_d;
      cells_q  <= cells_d;
      win_q    <= win_d;
      turn_q   <= turn_d;
      player_q <= player_d;
      dir_q    <= dir_d;
      draw_q   <= draw_d;
      err_q    <= err_d;
      neg_q    <= neg_d;
      moves_q  <= moves_d;
      cnt_q    <= cnt_d;
      lrow_q   <= lrow_d;
      lcol_q   <= lcol_d;
      pr_q     <= pr_d;
      pc_q     <= pc_d;
    end
  end

  assign mv.move_ready = (state_q == IDLE);
  assign mv.move_err   = err_q;
  assign busy          = (state_q == SCAN);
  assign win           = win_q;
  assign draw          = draw_q;
  assign moves         = moves_q;
  assign rd_cell       = cell_at(cells_q, int'(rd_row), int'(rd_col));
endmodule

// File: tb/tb_nxn_board_engine.sv
// Bench for nxn_board_engine: a 3x3/K=3 and a 5x5/K=4 instance checked against a
// reference board model through an expected-result queue.
module tb_nxn_board_engine;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, clear;
  nxn_board_engine_if #(.N(3)) if3();
  nxn_board_engine_if #(.N(5)) if5();

  logic [1:0] rd_row3, rd_col3, cell3, win3;
  logic [2:0] rd_row5, rd_col5;
  logic [1:0] cell5, win5;
  logic       draw3, draw5, busy3, busy5;
  logic [3:0] moves3;
  logic [4:0] moves5;

  nxn_board_engine #(.N(3), .K(3)) u3 (
    .clk(clk), .reset(rst_n), .clear(clear), .mv(if3),
    .rd_row(rd_row3), .rd_col(rd_col3), .rd_cell(cell3),
    .win(win3), .draw(draw3), .busy(busy3), .moves(moves3)
  );

  nxn_board_engine #(.N(5), .K(4)) u5 (
    .clk(clk), .reset(rst_n), .clear(clear), .mv(if5),
    .rd_row(rd_row5), .rd_col(rd_col5), .rd_cell(cell5),
    .win(win5), .draw(draw5), .busy(busy5), .moves(moves5)
  );

  typedef struct {
    logic       err;
    int         moves;
    logic [1:0] win;
    logic       draw;
    logic       over;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  // reference model: full-board search, independent of the last-move scan
  int         mn, mk, mmoves;
  logic [1:0] mb [5][5];
  logic [1:0] mturn, mwin;
  logic       mdraw;

  function automatic void model_reset(input int n, input int k);
    mn = n; mk = k; mmoves = 0;
    mturn = 2'b01; mwin = 2'b00; mdraw = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++) mb[r][c] = 2'b00;
  endfunction

  function automatic logic model_has_run(input logic [1:0] p);
    int dr, dc, rr, cc;
    logic ok;
    for (int r = 0; r < mn; r++)
      for (int c = 0; c < mn; c++)
        for (int d = 0; d < 4; d++) begin
          case (d)
            0: begin dr = 0; dc = 1;  end
            1: begin dr = 1; dc = 0;  end
            2: begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
          endcase
          ok = 1'b1;
          for (int t = 0; t < mk; t++) begin
            rr = r + t*dr; cc = c + t*dc;
            if (rr < 0 || rr >= mn || cc < 0 || cc >= mn) ok = 1'b0;
            else if (mb[rr][cc] != p) ok = 1'b0;
          end
          if (ok) return 1'b1;
        end
    return 1'b0;
  endfunction

  function automatic exp_t model_move(input logic [1:0] p, input int r, input int c);
    exp_t e;
    e.over = (mwin != 2'b00) || mdraw;
    e.err  = e.over || p == 2'b00 || p == 2'b11 || p != mturn || r >= mn || c >= mn;
    if (!e.err) e.err = (mb[r][c] != 2'b00);
    if (!e.err) begin
      mb[r][c] = p;
      mmoves++;
      mturn = mturn ^ 2'b11;
      if (model_has_run(p)) mwin = p;
      else if (mmoves == mn*mn) mdraw = 1'b1;
    end
    e.moves = mmoves; e.win = mwin; e.draw = mdraw;
    return e;
  endfunction

  function automatic logic get_ready(input int sel); return (sel == 3) ? if3.move_ready : if5.move_ready; endfunction
  function automatic logic get_err(input int sel);   return (sel == 3) ? if3.move_err   : if5.move_err;   endfunction
  function automatic logic get_busy(input int sel);  return (sel == 3) ? busy3 : busy5;  endfunction
  function automatic logic get_draw(input int sel);  return (sel == 3) ? draw3 : draw5;  endfunction
  function automatic logic [1:0] get_win(input int sel); return (sel == 3) ? win3 : win5; endfunction
  function automatic int get_moves(input int sel);   return (sel == 3) ? int'(moves3) : int'(moves5); endfunction

  task automatic drive(input int sel, input logic v, input logic [1:0] p, input int r, input int c);
    if (sel == 3) begin
      if3.move_valid = v; if3.move_player = p; if3.move_row = 2'(r); if3.move_col = 2'(c);
    end else begin
      if5.move_valid = v; if5.move_player = p; if5.move_row = 3'(r); if5.move_col = 3'(c);
    end
  endtask

  task automatic read_cell(input int sel, input int r, input int c, output logic [1:0] v);
    if (sel == 3) begin rd_row3 = 2'(r); rd_col3 = 2'(c); end
    else          begin rd_row5 = 3'(r); rd_col5 = 3'(c); end
    #1;
    v = (sel == 3) ? cell3 : cell5;
  endtask

  task automatic clear_game();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
  endtask

  // Issue one request (from a negedge), follow it through SCAN, then score it.
  task automatic send(input int sel, input logic [1:0] p, input int r, input int c);
    exp_t e, x;
    int w, sc;
    logic obs_err;
    e = model_move(p, r, c);
    sb.push_back(e);
    w = 0;
    while (!e.over && !get_ready(sel) && w < 100) begin @(negedge clk); w++; end
    if (w >= 100) begin errors++; $display("FAIL ready_timeout: got waited %0d want <100", w); end
    drive(sel, 1'b1, p, r, c);
    @(posedge clk);
    @(negedge clk);
    drive(sel, 1'b0, 2'b00, 0, 0);
    obs_err = get_err(sel);
    sc = 0;
    while (get_busy(sel) && sc < 100) begin @(negedge clk); sc++; end
    x = sb.pop_front();
    checks++; if (obs_err !== x.err) begin errors++; $display("FAIL move_err(%0d,%0d): got %0b want %0b", r, c, obs_err, x.err); end
    checks++; if (get_moves(sel) !== x.moves) begin errors++; $display("FAIL moves: got %0d want %0d", get_moves(sel), x.moves); end
    checks++; if (get_win(sel) !== x.win) begin errors++; $display("FAIL win: got %0b want %0b", get_win(sel), x.win); end
    checks++; if (get_draw(sel) !== x.draw) begin errors++; $display("FAIL draw: got %0b want %0b", get_draw(sel), x.draw); end
    checks++; if (sc > 8*(mk-1)) begin errors++; $display("FAIL scan_len: got %0d want <=%0d", sc, 8*(mk-1)); end
  endtask

  task automatic test_reset();
    logic [1:0] v;
    logic nz;
    checks++; if (if3.move_ready !== 1'b1 || busy3 !== 1'b0 || if3.move_err !== 1'b0) begin
      errors++; $display("FAIL reset_ctl: got ready=%0b busy=%0b err=%0b want 1 0 0", if3.move_ready, busy3, if3.move_err); end
    checks++; if (win3 !== 2'b00 || draw3 !== 1'b0 || moves3 !== 4'd0) begin
      errors++; $display("FAIL reset_status: got win=%0b draw=%0b moves=%0d want 0 0 0", win3, draw3, moves3); end
    nz = 1'b0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) begin read_cell(3, r, c, v); if (v !== 2'b00) nz = 1'b1; end
    checks++; if (nz) begin errors++; $display("FAIL reset_board: got nonzero cell want all 00"); end
  endtask

  task automatic test_win_row();
    clear_game(); model_reset(3, 3);
    send(3, 2'b01, 0, 0); send(3, 2'b10, 1, 0); send(3, 2'b01, 0, 1);
    send(3, 2'b10, 1, 1); send(3, 2'b01, 0, 2);
    checks++; if (if3.move_ready !== 1'b0 || busy3 !== 1'b0) begin
      errors++; $display("FAIL win_over_state: got ready=%0b busy=%0b want 0 0", if3.move_ready, busy3); end
  endtask

  task automatic test_occupied();
    logic [1:0] v;
    clear_game(); model_reset(3, 3);
    send(3, 2'b01, 1, 1);
    send(3, 2'b10, 1, 1);
    @(negedge clk);
    checks++; if (if3.move_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: got %0b want 0", if3.move_err); end
    read_cell(3, 1, 1, v);
    checks++; if (v !== 2'b01) begin errors++; $display("FAIL occupied_cell: got %0b want 01", v); end
    send(3, 2'b10, 0, 0);
  endtask

  task automatic test_illegal();
    logic [1:0] v;
    logic nz;
    clear_game(); model_reset(3, 3);
    send(3, 2'b10, 0, 0);
    send(3, 2'b11, 0, 0);
    send(3, 2'b00, 2, 2);
    send(3, 2'b01, 3, 0);
    send(3, 2'b01, 1, 3);
    nz = 1'b0;
    for (int r = 0; r < 3; r++) for (int c = 0; c < 3; c++) begin read_cell(3, r, c, v); if (v !== 2'b00) nz = 1'b1; end
    checks++; if (nz) begin errors++; $display("FAIL illegal_board: got nonzero cell want all 00"); end
    read_cell(3, 3, 0, v);
    checks++; if (v !== 2'b00) begin errors++; $display("FAIL rd_out_of_range: got %0b want 00", v); end
  endtask

  task automatic test_draw();
    clear_game(); model_reset(3, 3);
    send(3, 2'b01, 0, 0); send(3, 2'b10, 0, 1); send(3, 2'b01, 0, 2);
    send(3, 2'b10, 1, 1); send(3, 2'b01, 1, 0); send(3, 2'b10, 1, 2);
    send(3, 2'b01, 2, 1); send(3, 2'b10, 2, 0); send(3, 2'b01, 2, 2);
    checks++; if (draw3 !== 1'b1 || moves3 !== 4'd9) begin
      errors++; $display("FAIL draw_final: got draw=%0b moves=%0d want 1 9", draw3, moves3); end
  endtask

  task automatic test_diag5();
    clear_game(); model_reset(5, 4);
    send(5, 2'b01, 0, 0); send(5, 2'b10, 0, 4); send(5, 2'b01, 3, 3);
    send(5, 2'b10, 1, 4); send(5, 2'b01, 1, 1); send(5, 2'b10, 4, 0);
    send(5, 2'b01, 2, 2);
    checks++; if (win5 !== 2'b01) begin errors++; $display("FAIL diag5_win: got %0b want 01", win5); end
  endtask

  task automatic test_over_err();
    send(5, 2'b10, 4, 4); send(5, 2'b10, 4, 4); send(5, 2'b10, 3, 4);
    clear_game(); model_reset(5, 4);
    checks++; if (if5.move_ready !== 1'b1 || win5 !== 2'b00 || moves5 !== 5'd0) begin
      errors++; $display("FAIL clear_from_over: got ready=%0b win=%0b moves=%0d want 1 0 0", if5.move_ready, win5, moves5); end
  endtask

  task automatic test_back_to_back();
    exp_t e1, e2, x;
    int w;
    logic seen_err;
    clear_game(); model_reset(3, 3);
    sb.push_back(model_move(2'b01, 1, 1));
    sb.push_back(model_move(2'b10, 0, 0));
    drive(3, 1'b1, 2'b01, 1, 1);
    @(posedge clk); @(negedge clk);
    drive(3, 1'b1, 2'b10, 0, 0);
    seen_err = 1'b0; w = 0;
    while (!if3.move_ready && w < 100) begin
      if (if3.move_err) seen_err = 1'b1;
      @(negedge clk); w++;
    end
    e1 = sb.pop_front();
    checks++; if (seen_err !== e1.err || w >= 100) begin
      errors++; $display("FAIL hold_during_scan: got err=%0b wait=%0d want err=%0b", seen_err, w, e1.err); end
    @(posedge clk); @(negedge clk);
    drive(3, 1'b0, 2'b00, 0, 0);
    e2 = sb.pop_front();
    x = e2;
    checks++; if (if3.move_err !== x.err) begin errors++; $display("FAIL b2b_err: got %0b want %0b", if3.move_err, x.err); end
    w = 0;
    while (busy3 && w < 100) begin @(negedge clk); w++; end
    checks++; if (int'(moves3) !== x.moves) begin errors++; $display("FAIL b2b_moves: got %0d want %0d", moves3, x.moves); end
  endtask

  task automatic test_clear_wins();
    logic [1:0] v;
    @(negedge clk);
    clear = 1'b1;
    drive(3, 1'b1, 2'b01, 0, 0);
    @(negedge clk);
    clear = 1'b0;
    drive(3, 1'b0, 2'b00, 0, 0);
    model_reset(3, 3);
    read_cell(3, 0, 0, v);
    checks++; if (v !== 2'b00 || moves3 !== 4'd0 || if3.move_ready !== 1'b1 || if3.move_err !== 1'b0) begin
      errors++; $display("FAIL clear_vs_move: got cell=%0b moves=%0d ready=%0b err=%0b want 00 0 1 0", v, moves3, if3.move_ready, if3.move_err); end
  endtask

  task automatic test_reset_mid_scan();
    logic [1:0] v;
    @(negedge clk);
    drive(3, 1'b1, 2'b01, 0, 0);
    @(posedge clk); @(negedge clk);
    drive(3, 1'b0, 2'b00, 0, 0);
    checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL scan_started: got busy=%0b want 1", busy3); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (busy3 !== 1'b0 || moves3 !== 4'd0 || if3.move_ready !== 1'b1 || win3 !== 2'b00 || draw3 !== 1'b0) begin
      errors++; $display("FAIL async_reset: got busy=%0b moves=%0d ready=%0b win=%0b draw=%0b want 0 0 1 0 0", busy3, moves3, if3.move_ready, win3, draw3); end
    read_cell(3, 0, 0, v);
    checks++; if (v !== 2'b00) begin errors++; $display("FAIL async_reset_cell: got %0b want 00", v); end
    @(negedge clk); rst_n = 1'b1;
    model_reset(3, 3);
    send(3, 2'b01, 2, 2);
  endtask

  initial begin
    rst_n = 1'b0; clear = 1'b0;
    rd_row3 = '0; rd_col3 = '0; rd_row5 = '0; rd_col5 = '0;
    drive(3, 1'b0, 2'b00, 0, 0);
    drive(5, 1'b0, 2'b00, 0, 0);
    model_reset(3, 3);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_win_row();
    test_occupied();
    test_illegal();
    test_draw();
    test_diag5();
    test_over_err();
    test_back_to_back();
    test_clear_wins();
    test_reset_mid_scan();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 200000ns want finish earlier");
    $fatal(1, "timeout");
  end
endmodule
